fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage and IF/ID pipeline register. It consumes the stall/flush vectors and the branch redirect that the pipeline controller issues. It owns the PC, drives a single-outstanding request/ack instruction-memory port, and absorbs memory wait states by inserting bubbles. A one-entry hold buffer parks any instruction that returns while IF/ID is stalled.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `NOP_INST`, 32'h0000_0013: bubble encoding (addi x0,x0,0).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset. Asynchronous, active-low: asserted at 0.
- `stall`  in  6  from ctrl. Bit 0 holds the PC. Bit 1 holds IF/ID. Other bits are ignored.
- `flush`  in  6  from ctrl. Bit 1 loads a bubble into IF/ID. Other bits are ignored.
- `branch_flag`  in  1  redirect request from EX.
- `branch_target`  in  32  redirect address. Bits [1:0] are forced to 0.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address. Stable while `imem_req` is high and unacked.
- `imem_ack`  in  1  memory response valid. May assert in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction. Valid when `imem_ack` is 1.
- `if_id_pc`  out  32  IF/ID PC.
- `if_id_inst`  out  32  IF/ID instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction.

## Operation
- **States.** IDLE (no request outstanding), WAIT (request outstanding), DROP (outstanding request whose data must be discarded).
- **Registers.** `pc` (next fetch address), `req_addr`, hold buffer (`buf_valid`, `buf_pc`, `buf_inst`).
- **Fetch completion.** A fetch completes on a rising edge where `imem_req && imem_ack` are both 1.
- **Request generation.**
  - In IDLE: `imem_req = !stall[0] && !buf_valid && !branch_flag`, and `imem_addr = pc`.
  - In WAIT and DROP: `imem_req = 1` and `imem_addr = req_addr`.
- **IDLE transitions.**
  - Request issued without ack: latch `req_addr = pc`, go to WAIT.
  - Request issued with ack in the same cycle: complete the fetch and stay in IDLE.
  - In both cases `pc <= pc + 4`.
- **WAIT transitions.**
  - `imem_ack` asserted: complete the fetch and go to IDLE.
  - `branch_flag` asserted without ack: go to DROP.
- **DROP.** On `imem_ack`, discard the data and go to IDLE.
- **Destination of a completed fetch** (data `imem_rdata`, address `imem_addr`):
  - If `stall[1]` is 0, it loads IF/ID with valid = 1.
  - If `stall[1]` is 1, it loads the hold buffer.
- **IF/ID update, priority order:**
  1. `branch_flag` or `flush[1]`: bubble (pc 0, `NOP_INST`, valid 0).
  2. `stall[1]`: hold the current contents.
  3. `buf_valid`: load the buffer contents and clear the buffer.
  4. Fetch completes this cycle: load the fetched instruction.
  5. Otherwise: bubble.
- **Redirect** (`branch_flag` = 1): it wins over any stall.
  - `pc <= {branch_target[31:2], 2'b00}`.
  - Hold buffer cleared.
  - A fetch completing in the same cycle is discarded.
  - No new request is issued in IDLE that cycle.
  - WAIT without ack goes to DROP.
- **Arithmetic.** `pc + 4` is a 32-bit modular add: 32'hFFFF_FFFC wraps to 0.
- **Single-entry buffer.** The buffer is never overwritten, because no request is issued while `buf_valid` is 1.

## Timing
- **Reset values.**
  - Outputs: `imem_req` 0, `imem_addr` `RESET_PC`, `if_id_pc` 0, `if_id_inst` `NOP_INST`, `if_id_valid` 0.
  - Internal: state IDLE, `pc` = `RESET_PC`, `buf_valid` 0.
- **Reset is asynchronous.** Asserting `rst` mid-WAIT aborts immediately to the reset values. The memory must tolerate the dropped request.
- **First request.** It is issued in the first cycle after `rst` deasserts, provided `stall[0]` is 0.
- **Latency.** A fetch acked in cycle n appears on `if_id_*` in cycle n+1.
- **Throughput.**
  - Zero-wait memory: 1 instruction per cycle.
  - k wait states: 1 instruction per k+1 cycles, with k bubbles between instructions.
- **Redirect latency.**
  - From IDLE: the first fetch of the target is requested in the cycle after `branch_flag`.
  - From WAIT: the target fetch is requested in the cycle after the dropped ack.
- **Stall behaviour.** `stall[0]` only blocks new requests; an outstanding request still completes.
- **Outputs.** `imem_req` and `imem_addr` are combinational from state, `stall[0]`, `buf_valid` and `branch_flag`. All `if_id_*` outputs are registered.

## Test plan
- **Reset and first fetches.** Release reset with zero-wait memory and no stalls. Required: requests to 0x0, 0x4, 0x8 on consecutive cycles; `if_id_valid` = 1 from cycle 2; `if_id_pc` = 0x0, 0x4, 0x8.
- **Wait states.** Memory with 2 wait states. Required: `imem_addr` stable at 0x4 for 3 cycles; IF/ID shows 2 bubbles (`NOP_INST`, valid 0) between the instructions at 0x0 and 0x4.
- **Stall during outstanding fetch.** Assert `stall[0]` and `stall[1]` for 3 cycles while the fetch of 0x8 is outstanding; ack arrives during the stall. Required: IF/ID holds 0x4; no new request; after the stall drops, IF/ID = 0x8 from the buffer on the next edge, then a request to 0xC.
- **Branch during WAIT.** `branch_flag` with target 0x103 while the fetch of 0x10 is unacked. Required: IF/ID bubble; the 0x10 ack data is discarded; next request to 0x100; `if_id_pc` = 0x100.
- **Branch with simultaneous stall and ack.** `branch_flag` with target 0x200, `stall[1]` = 1 and an ack, all in the same cycle. Required: the acked instruction is discarded; IF/ID bubble; buffer empty; next request to 0x200.
- **PC wrap.** `branch_flag` with target 0xFFFF_FFFC. Required: requests to 0xFFFF_FFFC, then 0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC, single-outstanding imem request/ack port, one-entry hold buffer and IF/ID register
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [5:0]  stall_i,
  input  logic [5:0]  flush_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_inst_o,
  output logic        if_id_valid_o
);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, req_addr_q, req_addr_d;
  logic [31:0] buf_pc_q, buf_pc_d, buf_inst_q, buf_inst_d;
  logic [31:0] id_pc_q, id_pc_d, id_inst_q, id_inst_d;
  logic        buf_valid_q, buf_valid_d, id_valid_q, id_valid_d;
  logic        idle, issue, done, park, take_buf, bubble;
  logic        unused;
  assign unused = ^{stall_i[5:2], flush_i[5:2], flush_i[0], branch_target_i[1:0]};
  always_comb begin
    idle        = state_q == IDLE;
    imem_req_o  = idle ? (rst_ni && !stall_i[0] && !buf_valid_q && !branch_flag_i) : 1'b1;
    imem_addr_o = idle ? pc_q : req_addr_q;
    issue       = idle && imem_req_o;
    // a redirect or a DROP state discards whatever returns this cycle
    done        = imem_req_o && imem_ack_i && state_q != DROP && !branch_flag_i;
    park        = done && stall_i[1];
    take_buf    = !branch_flag_i && !flush_i[1] && !stall_i[1] && buf_valid_q;
    bubble      = branch_flag_i || flush_i[1] || (!stall_i[1] && !buf_valid_q && !done);
    state_d     = idle ? ((issue && !imem_ack_i) ? WAIT : IDLE)
                : imem_ack_i ? IDLE
                : (state_q == WAIT && branch_flag_i) ? DROP : state_q;
    pc_d        = branch_flag_i ? {branch_target_i[31:2], 2'b00} : issue ? pc_q + 32'd4 : pc_q;
    req_addr_d  = issue ? pc_q : req_addr_q;
    buf_valid_d = branch_flag_i ? 1'b0 : park ? 1'b1 : take_buf ? 1'b0 : buf_valid_q;
    buf_pc_d    = park ? imem_addr_o : buf_pc_q;
    buf_inst_d  = park ? imem_rdata_i : buf_inst_q;
    id_pc_d     = bubble ? 32'd0 : stall_i[1] ? id_pc_q : buf_valid_q ? buf_pc_q : imem_addr_o;
    id_inst_d   = bubble ? NOP_INST : stall_i[1] ? id_inst_q : buf_valid_q ? buf_inst_q : imem_rdata_i;
    id_valid_d  = bubble ? 1'b0 : stall_i[1] ? id_valid_q : 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= 32'd0;
      buf_inst_q  <= NOP_INST;
      id_pc_q     <= 32'd0;
      id_inst_q   <= NOP_INST;
      id_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_inst_q  <= buf_inst_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
      id_valid_q  <= id_valid_d;
    end
  end
  assign if_id_pc_o    = id_pc_q;
  assign if_id_inst_o  = id_inst_q;
  assign if_id_valid_o = id_valid_q;
endmodule
